// File: rtl/pwm_capture.sv
// Pulse-train capture: synchronizes pwm_in, then measures high time and period in clk cycles.
// Emits one valid strobe per completed period and a timeout strobe when an expected edge never comes.
module pwm_capture #(
  parameter int          SYNC_STAGES = 2,
  parameter int          CNT_W       = 32,
  parameter int unsigned TIMEOUT     = 32'd5000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] dutty,
  output logic             valid,
  output logic             timeout,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_HIGH = 2'd2,
    S_LOW  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_LIM  = CNT_W'(TIMEOUT);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_s_d;
  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt_p;
  logic [CNT_W-1:0]       r_cnt_h;
  logic [CNT_W-1:0]       r_cnt_to;
  logic [CNT_W-1:0]       r_period;
  logic [CNT_W-1:0]       r_dutty;
  logic                   r_valid;
  logic                   r_timeout;

  logic   w_s;
  logic   w_rise;
  logic   w_fall;
  logic   w_to_hit;
  state_t w_next;
  logic   w_start;
  logic   w_capture;
  logic   w_timeout;
  logic   w_enter;

  // Edge detect sits after the synchronizer so rise and fall see the same delay.
  assign w_s    = r_sync[SYNC_STAGES-1];
  assign w_rise = w_s & ~r_s_d;
  assign w_fall = ~w_s & r_s_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= '0;
      r_s_d  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], pwm_in};
      r_s_d  <= w_s;
    end
  end

  assign w_to_hit = (r_cnt_to >= TO_LIM);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Edges take priority over the timeout, so a coinciding rise still reports.
  always_comb begin
    w_next    = r_state;
    w_start   = 1'b0;
    w_capture = 1'b0;
    w_timeout = 1'b0;
    if (!enable) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: w_next = S_ARM;
        S_ARM: begin
          if (w_rise) begin
            w_next  = S_HIGH;
            w_start = 1'b1;
          end else if (w_to_hit) begin
            w_next    = S_ARM;
            w_timeout = 1'b1;
          end
        end
        S_HIGH: begin
          if (w_fall) begin
            w_next = S_LOW;
          end else if (w_to_hit) begin
            w_next    = S_ARM;
            w_timeout = 1'b1;
          end
        end
        S_LOW: begin
          if (w_rise) begin
            w_next    = S_HIGH;
            w_start   = 1'b1;
            w_capture = 1'b1;
          end else if (w_to_hit) begin
            w_next    = S_ARM;
            w_timeout = 1'b1;
          end
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  assign w_enter = (w_next != r_state) || w_timeout;

  // The state-local timeout counter reads 1 in the first cycle of each state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt_to <= '0;
      r_cnt_p  <= '0;
      r_cnt_h  <= '0;
    end else begin
      if (w_next == S_IDLE)          r_cnt_to <= '0;
      else if (w_enter)              r_cnt_to <= {{(CNT_W-1){1'b0}}, 1'b1};
      else if (r_cnt_to != CNT_MAX)  r_cnt_to <= r_cnt_to + 1'b1;

      if (w_next == S_IDLE || w_next == S_ARM) begin
        r_cnt_p <= '0;
        r_cnt_h <= '0;
      end else if (w_start) begin
        r_cnt_p <= {{(CNT_W-1){1'b0}}, 1'b1};
        r_cnt_h <= {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        if (r_cnt_p != CNT_MAX) r_cnt_p <= r_cnt_p + 1'b1;
        if (r_state == S_HIGH && !w_fall && r_cnt_h != CNT_MAX) r_cnt_h <= r_cnt_h + 1'b1;
      end
    end
  end

  // valid/timeout are single-cycle strobes with no back-pressure; period/dutty are
  // stable from the valid cycle until the next valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_period  <= '0;
      r_dutty   <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_valid   <= w_capture;
      r_timeout <= w_timeout;
      if (w_capture) begin
        r_period <= r_cnt_p;
        r_dutty  <= r_cnt_h;
      end
    end
  end

  assign period    = r_period;
  assign dutty     = r_dutty;
  assign valid     = r_valid;
  assign timeout   = r_timeout;
  assign busy      = (r_state != S_IDLE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: hand-computed periods, latencies and timeout intervals.
module tb_pwm_capture;
  localparam int CNT_W = 32;
  localparam int TO    = 1000;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic             pwm_in;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] dutty;
  logic             valid;
  logic             timeout;
  logic             busy;
  logic [1:0]       dbg_state;

  pwm_capture #(.SYNC_STAGES(2), .CNT_W(CNT_W), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .enable(enable), .pwm_in(pwm_in),
    .period(period), .dutty(dutty), .valid(valid), .timeout(timeout),
    .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // scoreboard: expected {period, dutty} per valid strobe
  logic [63:0] exp_q[$];
  logic [63:0] exp_e;
  int vcyc_q[$];
  int tcyc_q[$];
  int rise_q[$];
  int n_valid = 0;
  int n_to    = 0;

  always @(negedge clk) begin
    if (valid) begin
      n_valid++;
      vcyc_q.push_back(cyc);
      if (exp_q.size() == 0) chk("unexpected_valid", 1, 0);
      else begin
        exp_e = exp_q.pop_front();
        chk("period", period, exp_e[63:32]);
        chk("dutty", dutty, exp_e[31:0]);
      end
    end
    if (timeout) begin
      n_to++;
      tcyc_q.push_back(cyc);
    end
    if (valid && timeout) chk("strobe_overlap", 1, 0);
  end

  // driver tasks (called at a falling edge)
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int h, input int l);
    rise_q.push_back(cyc);
    pwm_in = 1'b1;
    tick(h);
    pwm_in = 1'b0;
    tick(l);
  endtask

  task automatic expect_n(input int n, input logic [31:0] p, input logic [31:0] d);
    for (int i = 0; i < n; i++) exp_q.push_back({p, d});
  endtask

  int en_cyc;
  task automatic restart();
    enable = 1'b0;
    tick(3);
    rise_q.delete();
    vcyc_q.delete();
    tcyc_q.delete();
    enable = 1'b1;
    en_cyc = cyc;
    tick(3);
  endtask

  int v0, t0, r0;

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    pwm_in = 1'b0;
    tick(3);
    chk("rst_period", period, 0);
    chk("rst_dutty", dutty, 0);
    chk("rst_valid", valid, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_state", dbg_state, 0);
    reset = 1'b0;
    tick(2);
    chk("idle_busy", busy, 0);

    // 100-cycle period, 30 high, three periods -> two results
    restart();
    chk("t1_busy", busy, 1);
    chk("t1_arm", dbg_state, 1);
    v0 = n_valid; t0 = n_to;
    expect_n(2, 100, 30);
    for (int i = 0; i < 3; i++) pulse(30, 70);
    tick(5);
    chk("t1_valid_count", n_valid - v0, 2);
    chk("t1_timeouts", n_to - t0, 0);
    if (vcyc_q.size() >= 1 && rise_q.size() >= 2) chk("t1_latency", vcyc_q[0] - rise_q[1], 3);
    else chk("t1_latency_missing", 0, 1);

    // minimum waveform
    restart();
    v0 = n_valid; t0 = n_to;
    expect_n(5, 2, 1);
    for (int i = 0; i < 6; i++) pulse(1, 1);
    tick(5);
    chk("t2_valid_count", n_valid - v0, 5);
    chk("t2_timeouts", n_to - t0, 0);

    // constant low: timeout every TO cycles after ARM entry
    restart();
    v0 = n_valid; t0 = n_to;
    tick(3050);
    chk("t3_timeout_count", n_to - t0, 3);
    if (tcyc_q.size() >= 3) begin
      chk("t3_first_to", tcyc_q[0] - en_cyc, TO + 1);
      chk("t3_interval1", tcyc_q[1] - tcyc_q[0], TO);
      chk("t3_interval2", tcyc_q[2] - tcyc_q[1], TO);
    end else chk("t3_to_missing", tcyc_q.size(), 3);
    chk("t3_no_valid", n_valid - v0, 0);
    chk("t3_period_held", period, 2);
    chk("t3_dutty_held", dutty, 1);
    chk("t3_arm", dbg_state, 1);

    // constant high after a rise: timeout in HIGH, then two rises for a result
    restart();
    v0 = n_valid; t0 = n_to;
    r0 = cyc;
    pwm_in = 1'b1;
    tick(1010);
    chk("t4_timeout_count", n_to - t0, 1);
    if (tcyc_q.size() >= 1) chk("t4_to_time", tcyc_q[0] - r0, TO + 3);
    else chk("t4_to_missing", 0, 1);
    chk("t4_arm", dbg_state, 1);
    pwm_in = 1'b0;
    tick(20);
    chk("t4_no_valid_yet", n_valid - v0, 0);
    expect_n(2, 100, 40);
    for (int i = 0; i < 3; i++) pulse(40, 60);
    tick(5);
    chk("t4_valid_count", n_valid - v0, 2);
    chk("t4_timeouts", n_to - t0, 1);

    // disable mid-HIGH
    restart();
    v0 = n_valid;
    pwm_in = 1'b1;
    tick(10);
    enable = 1'b0;
    tick(1);
    chk("t5_busy_off", busy, 0);
    chk("t5_idle", dbg_state, 0);
    pwm_in = 1'b0;
    tick(5);
    chk("t5_no_valid", n_valid - v0, 0);
    chk("t5_period_held", period, 100);
    enable = 1'b1;
    tick(3);
    expect_n(2, 60, 25);
    for (int i = 0; i < 3; i++) pulse(25, 35);
    tick(5);
    chk("t5_valid_count", n_valid - v0, 2);

    // reset pulse mid-LOW
    restart();
    v0 = n_valid;
    pwm_in = 1'b1;
    tick(20);
    pwm_in = 1'b0;
    tick(10);
    chk("t6_low", dbg_state, 3);
    reset = 1'b1;
    tick(1);
    chk("t6_period", period, 0);
    chk("t6_dutty", dutty, 0);
    chk("t6_valid", valid, 0);
    chk("t6_timeout", timeout, 0);
    chk("t6_busy", busy, 0);
    chk("t6_idle", dbg_state, 0);
    reset = 1'b0;
    tick(3);
    chk("t6_resume_busy", busy, 1);
    expect_n(2, 40, 15);
    for (int i = 0; i < 3; i++) pulse(15, 25);
    tick(5);
    chk("t6_valid_count", n_valid - v0, 2);
    chk("t6_period_final", period, 40);

    chk("exp_q_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
